// File: rtl/memory_port_arbiter.sv
// Shares one memory port among NUM_REQ requesters and routes responses back in acceptance order.
// Optional round-robin arbitration is enabled by defining MEM_ARB_ROUND_ROBIN_EN (default: fixed priority).
module memory_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_OUTST  = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    s_req,
    input  logic [NUM_REQ-1:0]                    s_we,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    s_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]  s_be,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    s_wdata,
    output logic [NUM_REQ-1:0]                    s_gnt,
    output logic [NUM_REQ-1:0]                    s_rvalid,
    output logic [NUM_REQ-1:0]                    s_err,
    output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    s_rdata,
    output logic                                  m_req,
    output logic                                  m_we,
    output logic [ADDR_WIDTH-1:0]                 m_addr,
    output logic [DATA_WIDTH/8-1:0]               m_be,
    output logic [DATA_WIDTH-1:0]                 m_wdata,
    input  logic                                  m_gnt,
    input  logic                                  m_rvalid,
    input  logic                                  m_err,
    input  logic [DATA_WIDTH-1:0]                 m_rdata
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int PTW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNTW = $clog2(MAX_OUTST + 1);

    logic [IDW-1:0]  r_fifo [MAX_OUTST];
    logic [PTW-1:0]  r_wptr;
    logic [PTW-1:0]  r_rptr;
    logic [CNTW-1:0] r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_mreq;
    logic            w_accept;
    logic            w_pop;
    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_head;

    function automatic logic [PTW-1:0] ptr_inc(input logic [PTW-1:0] p);
        return (p == PTW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_count == CNTW'(MAX_OUTST));
    assign w_empty = (r_count == '0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] r_prio;
    int             w_idx;

    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = int'(r_prio) + i;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_found && s_req[w_idx]) begin
                w_win   = IDW'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= '0;
        end else if (w_accept) begin
            r_prio <= (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
        end
    end
`else
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && s_req[i]) begin
                w_win   = IDW'(i);
                w_found = 1'b1;
            end
        end
    end
`endif

    // Fullness is taken from registered occupancy only, so m_rvalid never reaches m_req.
    assign w_mreq   = !rst && (|s_req) && !w_full;
    assign w_accept = w_mreq && m_gnt;
    assign w_pop    = !rst && m_rvalid && !w_empty;
    assign w_head   = r_fifo[r_rptr];
    assign m_req    = w_mreq;

    always_comb begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_be    = '0;
        m_wdata = '0;
        s_gnt   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_mreq && (w_win == IDW'(i))) begin
                m_we    = s_we[i];
                m_addr  = s_addr[i];
                m_be    = s_be[i];
                m_wdata = s_wdata[i];
                s_gnt[i] = m_gnt;
            end
        end
    end

    always_comb begin
        s_rvalid = '0;
        s_err    = '0;
        s_rdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pop && (w_head == IDW'(i))) begin
                s_rvalid[i] = 1'b1;
                s_err[i]    = m_err;
                s_rdata[i]  = m_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_fifo[r_wptr] <= w_win;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)    r_rptr <= ptr_inc(r_rptr);
            if (w_accept && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_accept && w_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule
